// File: rtl/dbg_pkg.sv
// Shared debug constants and the register-dump FSM state encoding.
package dbg_pkg;

  localparam int unsigned DBG_NUM_REGS  = 32;
  localparam int unsigned DBG_SEL_W     = 5;
  localparam int unsigned DBG_XLEN      = 32;
  localparam logic [7:0]  DBG_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_SYNC = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6
  } dump_state_e;

endpackage

// File: rtl/word_serializer.sv
// Word-to-byte serializer with a valid/ready output, LSB first.
// A single byte can also be loaded; it is then presented as the last byte.
module word_serializer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_word_i,
  input  logic [XLEN-1:0] word_i,
  input  logic            load_byte_i,
  input  logic [7:0]      byte_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            accept_c_o,
  output logic            last_byte_c_o
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  logic [XLEN-1:0]  shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;

  assign tx_data_o     = shreg_q[7:0];
  assign tx_valid_o    = valid_q;
  assign accept_c_o    = valid_q && tx_ready_i;
  assign last_byte_c_o = (cnt_q == LAST_CNT);

  // Load has priority; otherwise shift one byte per accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_word_i) begin
      shreg_q <= word_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (load_byte_i) begin
      shreg_q <= XLEN'(byte_i);
      cnt_q   <= LAST_CNT;
      valid_q <= 1'b1;
    end else if (accept_c_o) begin
      if (last_byte_c_o) begin
        valid_q <= 1'b0;
      end else begin
        shreg_q <= shreg_q >> 8;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dbg_reg_dump.sv
// Debug register-dump engine: halts the core, walks the debug read select
// and streams SYNC, all register bytes and an XOR checksum over valid/ready.
module dbg_reg_dump
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS  = DBG_NUM_REGS,
  parameter int unsigned SEL_W     = DBG_SEL_W,
  parameter int unsigned XLEN      = DBG_XLEN,
  parameter logic [7:0]  SYNC_BYTE = DBG_SYNC_BYTE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dump_req,
  output logic             busy,
  output logic             done,
  output logic             core_clk_enable,
  output logic [SEL_W-1:0] dbg_reg_sel,
  input  logic [XLEN-1:0]  dbg_reg_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

  dump_state_e      state_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       csum_q;
  logic             busy_q;
  logic             done_q;
  logic             cce_q;

  logic             accept_c;
  logic             last_byte_c;
  logic             last_reg_c;
  logic             load_word_c;
  logic             load_byte_c;
  logic [7:0]       byte_c;

  assign busy            = busy_q;
  assign done            = done_q;
  assign core_clk_enable = cce_q;
  assign dbg_reg_sel     = sel_q;

  // Serializer load strobes: SYNC byte during HALT, register word in LOAD,
  // checksum (including the byte being accepted now) after the final byte.
  always_comb begin
    last_reg_c  = (sel_q == LAST_SEL);
    load_word_c = (state_q == ST_LOAD);
    load_byte_c = 1'b0;
    byte_c      = SYNC_BYTE;
    if (state_q == ST_HALT) begin
      load_byte_c = 1'b1;
    end else if ((state_q == ST_SEND) && accept_c && last_byte_c && last_reg_c) begin
      load_byte_c = 1'b1;
      byte_c      = csum_q ^ tx_data;
    end
  end

  word_serializer #(
    .XLEN (XLEN)
  ) u_ser (
    .clk           (clk),
    .rst           (rst),
    .load_word_i   (load_word_c),
    .word_i        (dbg_reg_data),
    .load_byte_i   (load_byte_c),
    .byte_i        (byte_c),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .accept_c_o    (accept_c),
    .last_byte_c_o (last_byte_c)
  );

  // Dump sequencer with registered status, select, checksum and clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cce_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dump_req) begin
            state_q <= ST_HALT;
            busy_q  <= 1'b1;
            cce_q   <= 1'b0;
            csum_q  <= '0;
            sel_q   <= '0;
          end
        end
        ST_HALT: state_q <= ST_SYNC;
        ST_SYNC: begin
          if (accept_c) state_q <= ST_LOAD;
        end
        ST_LOAD: state_q <= ST_SEND;
        ST_SEND: begin
          if (accept_c) begin
            csum_q <= csum_q ^ tx_data;
            if (last_byte_c) begin
              if (last_reg_c) begin
                state_q <= ST_CSUM;
              end else begin
                sel_q   <= sel_q + SEL_W'(1);
                state_q <= ST_LOAD;
              end
            end
          end
        end
        ST_CSUM: begin
          if (accept_c) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            cce_q   <= 1'b1;
            sel_q   <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_reg_dump.sv
// Bench for dbg_reg_dump: register-file model on the debug port, table of
// dump scenarios with hand-computed checksums and latencies.
module tb_dbg_reg_dump;

  localparam int unsigned NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_req;
  logic        busy;
  logic        done;
  logic        core_clk_enable;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] rf        [NREG];
  logic [31:0] init_vals [NREG];
  logic        preload;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_val;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dbg_reg_dump dut (
    .clk             (clk),
    .rst             (rst),
    .dump_req        (dump_req),
    .busy            (busy),
    .done            (done),
    .core_clk_enable (core_clk_enable),
    .dbg_reg_sel     (dbg_reg_sel),
    .dbg_reg_data    (dbg_reg_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  // Register file: core writes only land while the core clock is enabled.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREG; i++) rf[i] <= init_vals[i];
    end else if (wr_en && core_clk_enable) begin
      rf[wr_idx] <= wr_val;
    end
  end

  assign dbg_reg_data = rf[dbg_reg_sel];

  typedef struct {
    string      name;
    int         pat;
    int         rdy_mode;   // 0: always ready, 1: random ready
    int         req_reg;    // extra dump_req during SEND of this register, -1 none
    int         abort_reg;  // rst during SEND of this register, -1 none
    bit         wr_req;     // core write of x7 on the request cycle
    bit         spam;       // core write attempts while halted
    int         exp_len;
    logic [7:0] exp_csum;
    int         exp_done;   // expected done cycle, -1 when not fixed
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] pat_val(input int p, input int i);
    case (p)
      1:       return (i == 1) ? 32'h12345678 : 32'h0;
      2:       return 32'h01010101 * 32'(i);
      3:       return (i == 31) ? 32'hDEADBEEF : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cce"}, 32'(core_clk_enable), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sel"}, 32'(dbg_reg_sel), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] m [NREG];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  x;
    logic [7:0]  prev_td;
    logic        busy1;
    bit          prev_stall;
    bit          req_sent;
    bit          timed_out;
    int cyc, done_cyc, first_cyc, done_cnt, stab_err, cce_err, sel_err, post_err, post, fm;

    // expected frame from the register model
    for (int i = 0; i < NREG; i++) begin
      m[i]         = pat_val(v.pat, i);
      init_vals[i] = m[i];
    end
    if (v.wr_req) m[7] = 32'hCAFEF00D;
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(m[i][8*b +: 8]);
        x = x ^ m[i][8*b +: 8];
      end
    end
    exp_q.push_back(x);

    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    // cycle 0: request sampled
    @(negedge clk);
    dump_req = 1'b1;
    tx_ready = (v.rdy_mode == 0);
    wr_en    = v.wr_req;
    wr_idx   = 5'd7;
    wr_val   = 32'hCAFEF00D;

    cyc = 0; done_cyc = -1; first_cyc = -1; done_cnt = 0; stab_err = 0;
    cce_err = 0; sel_err = 0; post_err = 0; post = 0;
    prev_stall = 1'b0; req_sent = 1'b0; timed_out = 1'b0; prev_td = 8'h00; busy1 = 1'b0;

    while (1) begin
      @(negedge clk);
      cyc++;
      dump_req = 1'b0;
      wr_en    = 1'b0;
      if (cyc == 1) busy1 = busy;
      if (prev_stall && (!tx_valid || tx_data !== prev_td)) stab_err++;
      if (busy && !done && core_clk_enable !== 1'b0) cce_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (core_clk_enable !== 1'b1) cce_err++;
      end
      if (v.rdy_mode == 0 && cyc >= 3 && cyc < 3 + 5 * NREG && (cyc - 3) % 5 == 0) begin
        if (dbg_reg_sel !== 5'((cyc - 3) / 5) || tx_valid !== 1'b0) sel_err++;
      end
      if (done_cyc >= 0 && !done) begin
        post++;
        if (busy || tx_valid) post_err++;
      end
      if (post >= 12) break;
      if (cyc >= 3000) begin
        timed_out = 1'b1;
        break;
      end
      if (v.abort_reg >= 0 && tx_valid && busy && dbg_reg_sel == 5'(v.abort_reg)) begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs({v.name, "_post_rst"});
        rst = 1'b0;
        return;
      end
      tx_ready = (v.rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (v.spam && busy && !done) begin
        wr_en  = 1'b1;
        wr_idx = 5'd9;
        wr_val = 32'hFFFFFFFF;
      end
      if (v.req_reg >= 0 && !req_sent && tx_valid && dbg_reg_sel == 5'(v.req_reg)) begin
        dump_req = 1'b1;
        req_sent = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (first_cyc < 0) first_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_td    = tx_data;
    end

    check({v.name, "_timeout"}, 32'(timed_out), 32'd0);
    check({v.name, "_len"}, 32'(got_q.size()), 32'(v.exp_len));
    fm = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (fm < 0 && got_q[i] !== exp_q[i]) fm = i;
    end
    n_checks++;
    if (fm < 0 && got_q.size() == exp_q.size()) n_pass++;
    else if (fm >= 0)
      $display("FAIL %s_frame: byte %0d got %02h expected %02h", v.name, fm, got_q[fm], exp_q[fm]);
    else
      $display("FAIL %s_frame: got %0d bytes expected %0d", v.name, got_q.size(), exp_q.size());
    check({v.name, "_csum"}, (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hFFFF_FFFF,
          32'(v.exp_csum));
    check({v.name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({v.name, "_busy_halt"}, 32'(busy1), 32'd1);
    check({v.name, "_stable"}, 32'(stab_err), 32'd0);
    check({v.name, "_cce"}, 32'(cce_err), 32'd0);
    check({v.name, "_post_idle"}, 32'(post_err), 32'd0);
    if (v.exp_done >= 0) begin
      check({v.name, "_done_cyc"}, 32'(done_cyc), 32'(v.exp_done));
      check({v.name, "_sync_cyc"}, 32'(first_cyc), 32'd2);
      check({v.name, "_load_sel"}, 32'(sel_err), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"x1_ready",     1, 0, -1, -1, 1'b0, 1'b0, 130, 8'h08, 164};
    vecs[1] = '{"x1_random",    1, 1, -1, -1, 1'b0, 1'b0, 130, 8'h08, -1};
    vecs[2] = '{"ramp_ready",   2, 0, -1, -1, 1'b0, 1'b0, 130, 8'h00, 164};
    vecs[3] = '{"x31_random",   3, 1, -1, -1, 1'b0, 1'b0, 130, 8'h22, -1};
    vecs[4] = '{"req_in_send",  1, 0, 10, -1, 1'b0, 1'b0, 130, 8'h08, 164};
    vecs[5] = '{"write_at_req", 0, 0, -1, -1, 1'b1, 1'b1, 130, 8'hC9, 164};
    vecs[6] = '{"abort_r20",    1, 0, -1, 20, 1'b0, 1'b0, 130, 8'h08, -1};
    vecs[7] = '{"after_abort",  1, 1, -1, -1, 1'b0, 1'b0, 130, 8'h08, -1};

    rst      = 1'b1;
    dump_req = 1'b0;
    tx_ready = 1'b0;
    preload  = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = 5'd0;
    wr_val   = 32'h0;
    for (int i = 0; i < NREG; i++) init_vals[i] = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
